// File: rtl/ext_pkg.sv
// Shared encodings for the immediate extension pipeline: extension modes
// and the occupancy states of the output/skid storage.
package ext_pkg;

   // Extension mode, sampled together with the immediate field.
   typedef enum logic [1:0] {
      EXT_ZERO   = 2'b00,  // zero-extend
      EXT_SIGN   = 2'b01,  // sign-extend from the immediate MSB
      EXT_UPPER  = 2'b10,  // immediate placed in the top bits, zeros below
      EXT_BRANCH = 2'b11   // sign-extend, then shift left by 2 (word offset)
   } ext_mode_e;

   // Number of results held: none, output register only, output + skid.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } state_e;

endpackage

// File: rtl/ext_core.sv
// Purely combinational immediate extension. bus_size must exceed bus_size_in
// (and be at least 3 so the branch shift leaves a valid slice).
module ext_core
   import ext_pkg::*;
#(
   parameter int bus_size    = 32,
   parameter int bus_size_in = 16
) (
   input  logic [bus_size_in-1:0] i_imm,
   input  logic [1:0]             i_mode,
   output logic [bus_size-1:0]    o_ext
);

   localparam int PAD = bus_size - bus_size_in;

   logic [bus_size-1:0] w_zext;
   logic [bus_size-1:0] w_sext;
   logic [bus_size-1:0] w_upper;
   logic [bus_size-1:0] w_branch;

   assign w_zext   = {{PAD{1'b0}}, i_imm};
   assign w_sext   = {{PAD{i_imm[bus_size_in-1]}}, i_imm};
   assign w_upper  = {i_imm, {PAD{1'b0}}};
   // Bits shifted past the top are simply dropped.
   assign w_branch = {w_sext[bus_size-3:0], 2'b00};

   // Select the extended form requested by the mode field.
   always_comb begin
      o_ext = w_zext;
      case (i_mode)
         EXT_ZERO:   o_ext = w_zext;
         EXT_SIGN:   o_ext = w_sext;
         EXT_UPPER:  o_ext = w_upper;
         EXT_BRANCH: o_ext = w_branch;
         default:    o_ext = w_zext;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extension stage with a registered output and one skid entry.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; in_ready depends only on the registered state (never on
// out_ready), and out is driven only from a register so it stays stable
// while out_valid=1 and out_ready=0.
module imm_ext_pipe
   import ext_pkg::*;
#(
   parameter int bus_size    = 32,
   parameter int bus_size_in = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [bus_size_in-1:0] in,
   input  logic [1:0]             mode,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [bus_size-1:0]    out,
   output state_e                 dbg_state
);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [bus_size-1:0] r_out;
   logic [bus_size-1:0] r_skid;
   logic [bus_size-1:0] w_ext;
   logic                w_in_xfer;
   logic                w_out_xfer;
   logic                w_load_out;
   logic                w_load_skid;
   logic                w_out_from_skid;

   // Extension is computed here and captured at acceptance time.
   ext_core #(
      .bus_size    (bus_size),
      .bus_size_in (bus_size_in)
   ) u_ext_core (
      .i_imm  (in),
      .i_mode (mode),
      .o_ext  (w_ext)
   );

   assign in_ready   = (r_state != FULL);
   assign out_valid  = (r_state != EMPTY);
   assign out        = r_out;
   assign dbg_state  = r_state;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   // Occupancy next-state and register load controls; flush overrides all.
   always_comb begin
      w_state_nxt     = r_state;
      w_load_out      = 1'b0;
      w_load_skid     = 1'b0;
      w_out_from_skid = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_in_xfer) begin
               w_state_nxt = ONE;
               w_load_out  = 1'b1;
            end
         end
         ONE: begin
            if (w_in_xfer && w_out_xfer) begin
               w_load_out = 1'b1;
            end else if (w_in_xfer) begin
               w_state_nxt = FULL;
               w_load_skid = 1'b1;
            end else if (w_out_xfer) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            // in_ready is 0 here, so only the drain can happen.
            if (w_out_xfer) begin
               w_state_nxt     = ONE;
               w_load_out      = 1'b1;
               w_out_from_skid = 1'b1;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
      if (flush) begin
         w_state_nxt     = EMPTY;
         w_load_out      = 1'b0;
         w_load_skid     = 1'b0;
         w_out_from_skid = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output and skid storage; out keeps its last value when nothing loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out  <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_out) begin
            r_out <= w_out_from_skid ? r_skid : w_ext;
         end
         if (w_load_skid) begin
            r_skid <= w_ext;
         end
      end
   end

endmodule
